axi_lite_wr_master: RTL and testbench

AXI_LITE_WR_MASTER -- requirements
Module: axi_lite_wr_master

---
 rtl/axi_lite_wr_master.sv | 145 ++++++++++++++
 tb/tb_axi_lite_wr_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_wr_master.sv
// AXI4-Lite write master: turns one-cycle write requests into AW/W/B transactions,
// with a one-deep pending slot, completion counter and sticky error flags.
module axi_lite_wr_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lite_valid,
  input  logic [9:0]  lite_awaddr,
  input  logic [31:0] lite_wdata,
  output logic        lite_end,
  output logic        busy,
  input  logic        clr_err,
  output logic        resp_err,
  output logic        timeout_err,
  output logic        ovf_err,
  output logic [15:0] wr_count,
  output logic [9:0]  m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [9:0]  addr_q;
  logic [31:0] data_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        pend_full;
  logic [9:0]  pend_addr;
  logic [31:0] pend_data;
  logic [15:0] tmo_cnt;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic launch;
  logic pend_load;
  logic ovf_set;
  logic tmo_set;
  logic resp_set;

  assign aw_hs    = awvalid_q & m_axi_awready;
  assign w_hs     = wvalid_q & m_axi_wready;
  assign b_hs     = (state == RESP) & m_axi_bvalid;
  assign launch   = (state == IDLE) & (pend_full | lite_valid);
  // A pending entry leaving in this cycle frees its slot for a simultaneous request.
  assign pend_load = lite_valid & (((state == IDLE) & pend_full) | ((state != IDLE) & ~pend_full));
  assign ovf_set  = lite_valid & pend_full & (state != IDLE);
  assign tmo_set  = (state != IDLE) & (tmo_cnt == TMO_LAST);
  assign resp_set = b_hs & (m_axi_bresp != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_full | lite_valid) state_nxt = ADDR;
      ADDR:    if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs)) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awaddr  = addr_q;
    m_axi_wdata   = data_q;
    m_axi_awvalid = awvalid_q;
    m_axi_wvalid  = wvalid_q;
    m_axi_bready  = (state == RESP);
    m_axi_awprot  = 3'b000;
    m_axi_wstrb   = 4'hF;
    busy          = (state != IDLE) | pend_full;
  end

  // Pending slot always has priority over a fresh request when launching from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      pend_full   <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      tmo_cnt     <= '0;
      lite_end    <= 1'b0;
      wr_count    <= '0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (launch) begin
        addr_q    <= pend_full ? pend_addr : lite_awaddr;
        data_q    <= pend_full ? pend_data : lite_wdata;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        tmo_cnt   <= '0;
      end else begin
        if (aw_hs) awvalid_q <= 1'b0;
        if (w_hs) wvalid_q <= 1'b0;
        if ((state != IDLE) && (tmo_cnt != TMO_LAST)) tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (pend_load) begin
        pend_full <= 1'b1;
        pend_addr <= lite_awaddr;
        pend_data <= lite_wdata;
      end else if ((state == IDLE) && pend_full) begin
        pend_full <= 1'b0;
      end

      lite_end <= b_hs;
      if (b_hs) wr_count <= wr_count + 16'd1;

      resp_err    <= resp_set | (resp_err & ~clr_err);
      timeout_err <= tmo_set | (timeout_err & ~clr_err);
      ovf_err     <= ovf_set | (ovf_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_master.sv
// Randomised scoreboard bench for axi_lite_wr_master against a transaction-level model
// of request acceptance, handshake progress and error flags.
module tb_axi_lite_wr_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lite_valid = 1'b0;
  logic [9:0]  lite_awaddr = '0;
  logic [31:0] lite_wdata = '0;
  logic        lite_end;
  logic        busy;
  logic        clr_err = 1'b0;
  logic        resp_err;
  logic        timeout_err;
  logic        ovf_err;
  logic [15:0] wr_count;
  logic [9:0]  m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  axi_lite_wr_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .lite_valid(lite_valid), .lite_awaddr(lite_awaddr),
    .lite_wdata(lite_wdata), .lite_end(lite_end), .busy(busy), .clr_err(clr_err),
    .resp_err(resp_err), .timeout_err(timeout_err), .ovf_err(ovf_err), .wr_count(wr_count),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int end_seen = 0;
  bit mon_en = 1'b0;

  int p_aw = 100;
  int p_w = 100;
  int p_b = 100;
  int bresp_mode = 0;

  logic [9:0]  aw_q[$];
  logic [31:0] w_q[$];
  logic [15:0] end_q[$];

  // Reference model: one transaction in flight plus one waiting; acceptance decided per request.
  bit          m_active, m_aw_left, m_w_left, m_resp, m_pend, m_end;
  logic [9:0]  m_pend_addr;
  logic [31:0] m_pend_data;
  int          m_age;
  logic [15:0] m_count;
  bit          m_resp_err, m_tmo_err, m_ovf_err;
  int unsigned m_seq;

  task automatic accept(input logic [9:0] a, input logic [31:0] d);
    m_seq++;
    aw_q.push_back(a);
    w_q.push_back(d);
    end_q.push_back(16'(m_seq));
  endtask

  task automatic start_txn();
    m_active = 1'b1;
    m_aw_left = 1'b1;
    m_w_left = 1'b1;
    m_resp = 1'b0;
    m_age = 1;
  endtask

  task automatic model_step();
    bit b_hs, aw_hs, w_hs, rs, ts, os;
    if (rst) begin
      {m_active, m_aw_left, m_w_left, m_resp, m_pend, m_end} = '0;
      {m_resp_err, m_tmo_err, m_ovf_err} = '0;
      m_count = '0;
      m_seq = 0;
      m_age = 0;
      aw_q.delete();
      w_q.delete();
      end_q.delete();
      return;
    end
    b_hs  = m_active && m_resp && m_axi_bvalid;
    aw_hs = m_active && m_aw_left && m_axi_awready;
    w_hs  = m_active && m_w_left && m_axi_wready;
    rs = b_hs && (m_axi_bresp != 2'b00);
    ts = m_active && (m_age >= TMO);
    os = lite_valid && m_pend && m_active;
    m_resp_err = rs || (m_resp_err && !clr_err);
    m_tmo_err  = ts || (m_tmo_err && !clr_err);
    m_ovf_err  = os || (m_ovf_err && !clr_err);
    m_end = b_hs;
    if (b_hs) m_count = m_count + 16'd1;
    if (!m_active) begin
      if (m_pend) begin
        start_txn();
        m_pend = lite_valid;
        if (lite_valid) begin
          m_pend_addr = lite_awaddr;
          m_pend_data = lite_wdata;
          accept(lite_awaddr, lite_wdata);
        end
      end else if (lite_valid) begin
        accept(lite_awaddr, lite_wdata);
        start_txn();
      end
    end else begin
      if (lite_valid && !m_pend) begin
        m_pend = 1'b1;
        m_pend_addr = lite_awaddr;
        m_pend_data = lite_wdata;
        accept(lite_awaddr, lite_wdata);
      end
      m_age++;
      if (m_resp) begin
        if (b_hs) m_active = 1'b0;
      end else begin
        if (aw_hs) m_aw_left = 1'b0;
        if (w_hs) m_w_left = 1'b0;
        if (!m_aw_left && !m_w_left) m_resp = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and compares the control outputs every cycle.
  initial forever begin
    logic [23:0] act_v, exp_v;
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) checkOutput("aw_unexpected", {54'd0, m_axi_awaddr}, 64'hDEAD);
        else checkOutput("aw_addr", {54'd0, m_axi_awaddr}, {54'd0, aw_q.pop_front()});
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) checkOutput("w_unexpected", {32'd0, m_axi_wdata}, 64'hDEAD);
        else checkOutput("w_data", {32'd0, m_axi_wdata}, {32'd0, w_q.pop_front()});
      end
      if (lite_end) begin
        end_seen++;
        if (end_q.size() == 0) checkOutput("end_unexpected", {48'd0, wr_count}, 64'hDEAD);
        else checkOutput("end_count", {48'd0, wr_count}, {48'd0, end_q.pop_front()});
      end
      act_v = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, lite_end,
               resp_err, timeout_err, ovf_err, wr_count};
      exp_v = {m_active & m_aw_left, m_active & m_w_left, m_active & m_resp, m_active | m_pend,
               m_end, m_resp_err, m_tmo_err, m_ovf_err, m_count};
      checkOutput("cycle_ctrl", {40'd0, act_v}, {40'd0, exp_v});
    end
  end

  task automatic applyStimulus(input bit v, input logic [9:0] a, input logic [31:0] d,
                               input bit clr, input bit r);
    @(negedge clk);
    rst = r;
    lite_valid = v;
    lite_awaddr = a;
    lite_wdata = d;
    clr_err = clr;
    m_axi_awready = ($urandom_range(0, 99) < p_aw);
    m_axi_wready = ($urandom_range(0, 99) < p_w);
    m_axi_bvalid = ($urandom_range(0, 99) < p_b);
    case (bresp_mode)
      0: m_axi_bresp = 2'b00;
      1: m_axi_bresp = 2'b10;
      default: m_axi_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endcase
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    do begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      n++;
    end while (busy && n < max_cycles);
    checkOutput("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic set_slave(input int aw, input int w, input int b, input int mode);
    p_aw = aw;
    p_w = w;
    p_b = b;
    bresp_mode = mode;
  endtask

  initial begin
    int base_end;
    logic [9:0] five_addr[5];
    five_addr = '{10'h000, 10'h018, 10'h01C, 10'h028, 10'h004};

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_state",
      {21'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, lite_end, resp_err,
       timeout_err, ovf_err, wr_count, m_axi_awaddr, m_axi_wdata[7:0]}, 64'd0);
    checkOutput("reset_wdata", {32'd0, m_axi_wdata}, 64'd0);
    checkOutput("awprot_wstrb", {57'd0, m_axi_awprot, m_axi_wstrb}, {57'd0, 3'b000, 4'hF});
    mon_en = 1'b1;

    $display("[TB] single write");
    set_slave(100, 100, 100, 0);
    base_end = end_seen;
    applyStimulus(1'b1, 10'h018, 32'h1234_5678, 1'b0, 1'b0);
    wait_idle(40);
    checkOutput("single_count", {48'd0, wr_count}, 64'd1);
    checkOutput("single_errs", {61'd0, resp_err, timeout_err, ovf_err}, 64'd0);
    checkOutput("single_ends", 64'(end_seen - base_end), 64'd1);

    $display("[TB] skewed handshakes with early bvalid");
    set_slave(100, 25, 100, 0);
    base_end = end_seen;
    applyStimulus(1'b1, 10'h0A4, $urandom, 1'b0, 1'b0);
    wait_idle(200);
    checkOutput("skew_count", {48'd0, wr_count}, 64'd2);
    checkOutput("skew_ends", 64'(end_seen - base_end), 64'd1);

    $display("[TB] back-to-back with overflow");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    set_slave(50, 50, 50, 0);
    base_end = end_seen;
    applyStimulus(1'b1, 10'h100, 32'hAAAA_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h104, 32'hAAAA_0002, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h108, 32'hAAAA_0003, 1'b0, 1'b0);
    wait_idle(300);
    checkOutput("b2b_ovf", {63'd0, ovf_err}, 64'd1);
    checkOutput("b2b_count", {48'd0, wr_count}, 64'd2);
    checkOutput("b2b_ends", 64'(end_seen - base_end), 64'd2);

    $display("[TB] slave error response and clear");
    set_slave(100, 100, 100, 1);
    base_end = end_seen;
    applyStimulus(1'b1, 10'h3FC, 32'hCAFE_F00D, 1'b0, 1'b0);
    wait_idle(40);
    checkOutput("slverr_flag", {63'd0, resp_err}, 64'd1);
    checkOutput("slverr_ends", 64'(end_seen - base_end), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    checkOutput("clr_errs", {61'd0, resp_err, timeout_err, ovf_err}, 64'd0);

    $display("[TB] five-write address sequence");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    set_slave(100, 100, 100, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, five_addr[i], $urandom, 1'b0, 1'b0);
      wait_idle(40);
    end
    checkOutput("five_count", {48'd0, wr_count}, 64'd5);

    $display("[TB] randomised traffic");
    for (int blk = 0; blk < 8; blk++) begin
      set_slave($urandom_range(30, 95), $urandom_range(30, 95), $urandom_range(30, 95), 2);
      for (int i = 0; i < 50; i++)
        applyStimulus($urandom_range(0, 99) < 30, 10'($urandom), $urandom,
                      $urandom_range(0, 99) < 3, 1'b0);
    end
    set_slave(100, 100, 100, 0);
    wait_idle(300);
    checkOutput("sb_drain", 64'(aw_q.size() + w_q.size() + end_q.size()), 64'd0);

    $display("[TB] timeout then reset mid-transaction");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    set_slave(0, 0, 0, 0);
    applyStimulus(1'b1, 10'h2C0, 32'h5555_AAAA, 1'b0, 1'b0);
    idle_cycles(12);
    #2;
    checkOutput("tmo_flag", {63'd0, timeout_err}, 64'd1);
    checkOutput("tmo_valids", {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'b110);
    base_end = end_seen;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    checkOutput("abort_state",
      {21'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, lite_end, resp_err,
       timeout_err, ovf_err, wr_count, m_axi_awaddr, m_axi_wdata[7:0]}, 64'd0);
    idle_cycles(3);
    checkOutput("abort_no_end", 64'(end_seen - base_end), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
